// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - register bank request/response bundle
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] or_in;
    logic [DATA_W-1:0] alu_in;
    logic [1:0]        mux_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rs_a;
    logic [ADDR_W-1:0] rs_b;
    logic              swap_req;
    logic [DATA_W-1:0] dataout_A;
    logic [DATA_W-1:0] dataout_B;
    logic              busy;

    modport master (
        output or_in, alu_in, mux_sel, wr_en, wr_addr, rd_en, rs_a, rs_b, swap_req,
        input  dataout_A, dataout_B, busy
    );

    modport slave (
        input  or_in, alu_in, mux_sel, wr_en, wr_addr, rd_en, rs_a, rs_b, swap_req,
        output dataout_A, dataout_B, busy
    );
endinterface

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - register bank with write mux, bypassed dual read and two-cycle swap
module reg_bank #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);
    typedef enum logic {IDLE, SWAP2} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] tmp;
    logic [ADDR_W-1:0] swap_b;

    logic              a_ok, b_ok, w_ok;
    logic [DATA_W-1:0] rd_a, rd_b, wr_data;
    logic              do_write, do_read, swap_start, swap_finish;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

    // Address decode, out-of-range reads return zero, write source select
    always_comb begin
        a_ok = in_range(bus.rs_a);
        b_ok = in_range(bus.rs_b);
        w_ok = in_range(bus.wr_addr);
        rd_a = a_ok ? regs[bus.rs_a] : '0;
        rd_b = b_ok ? regs[bus.rs_b] : '0;
        case (bus.mux_sel)
            2'b00:   wr_data = bus.or_in;
            2'b01:   wr_data = bus.alu_in;
            2'b10:   wr_data = rd_a;
            default: wr_data = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state: only a fully in-range swap leaves IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.swap_req && a_ok && b_ok) next_state = SWAP2;
            SWAP2:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control strobes: swap_req masks same-cycle read/write, SWAP2 masks everything
    always_comb begin
        do_write    = 1'b0;
        do_read     = 1'b0;
        swap_start  = 1'b0;
        swap_finish = 1'b0;
        case (state)
            IDLE: begin
                swap_start = bus.swap_req && a_ok && b_ok;
                do_write   = !bus.swap_req && bus.wr_en && w_ok;
                do_read    = !bus.swap_req && bus.rd_en;
            end
            SWAP2:   swap_finish = 1'b1;
            default: ;
        endcase
    end

    // Busy mirrors the second swap cycle
    always_ff @(posedge clk) begin
        if (rst) bus.busy <= 1'b0;
        else     bus.busy <= swap_start;
    end

    // Register file: swap first half, swap second half, or ordinary write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            tmp    <= '0;
            swap_b <= '0;
        end else if (swap_start) begin
            tmp            <= rd_a;
            regs[bus.rs_a] <= rd_b;
            swap_b         <= bus.rs_b;
        end else if (swap_finish) begin
            regs[swap_b] <= tmp;
        end else if (do_write) begin
            regs[bus.wr_addr] <= wr_data;
        end
    end

    // Read ports with same-cycle write bypass; hold when not reading
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dataout_A <= '0;
            bus.dataout_B <= '0;
        end else if (do_read) begin
            bus.dataout_A <= (do_write && bus.wr_addr == bus.rs_a) ? wr_data : rd_a;
            bus.dataout_B <= (do_write && bus.wr_addr == bus.rs_b) ? wr_data : rd_b;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - scoreboard bench for reg_bank with 8- and 6-register builds
module tb_reg_bank;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus8 ();
    reg_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus6 ();

    reg_bank #(.DATA_W(DW), .NUM_REGS(8), .ADDR_W(AW)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    reg_bank #(.DATA_W(DW), .NUM_REGS(6), .ADDR_W(AW)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    typedef struct {
        logic [7:0] a8, b8, a6, b6;
        logic       bz8, bz6;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [7:0] mem [2][8];
    logic       mbusy [2];
    logic [7:0] moa [2];
    logic [7:0] mob [2];
    int         nregs [2] = '{8, 6};

    function automatic logic [7:0] rdm(input int k, input logic [2:0] x);
        return (int'(x) < nregs[k]) ? mem[k][x] : 8'h00;
    endfunction

    // Behavioural model: swap is an atomic exchange followed by one busy cycle
    task automatic model_step(input int k, input logic r, input logic [7:0] o, input logic [7:0] al,
                              input logic [1:0] ms, input logic we, input logic [2:0] wa,
                              input logic re, input logic [2:0] a, input logic [2:0] b, input logic sw);
        logic [7:0] wd, t;
        if (r) begin
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
            moa[k] = 8'h00; mob[k] = 8'h00; mbusy[k] = 1'b0;
        end else if (mbusy[k]) begin
            mbusy[k] = 1'b0;
        end else if (sw) begin
            if (int'(a) < nregs[k] && int'(b) < nregs[k]) begin
                t = mem[k][a]; mem[k][a] = mem[k][b]; mem[k][b] = t;
                mbusy[k] = 1'b1;
            end
        end else begin
            case (ms)
                2'd0:    wd = o;
                2'd1:    wd = al;
                2'd2:    wd = rdm(k, a);
                default: wd = 8'h00;
            endcase
            if (we && int'(wa) < nregs[k]) mem[k][wa] = wd;
            if (re) begin
                moa[k] = rdm(k, a);
                mob[k] = rdm(k, b);
            end
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] o, input logic [7:0] al, input logic [1:0] ms,
                         input logic we, input logic [2:0] wa, input logic re,
                         input logic [2:0] a, input logic [2:0] b, input logic sw);
        exp_t e;
        rst = r;
        bus8.or_in = o;  bus8.alu_in = al; bus8.mux_sel = ms; bus8.wr_en = we; bus8.wr_addr = wa;
        bus8.rd_en = re; bus8.rs_a = a;    bus8.rs_b = b;     bus8.swap_req = sw;
        bus6.or_in = o;  bus6.alu_in = al; bus6.mux_sel = ms; bus6.wr_en = we; bus6.wr_addr = wa;
        bus6.rd_en = re; bus6.rs_a = a;    bus6.rs_b = b;     bus6.swap_req = sw;
        for (int k = 0; k < 2; k++) model_step(k, r, o, al, ms, we, wa, re, a, b, sw);
        e.a8 = moa[0]; e.b8 = mob[0]; e.bz8 = mbusy[0];
        e.a6 = moa[1]; e.b6 = mob[1]; e.bz6 = mbusy[1];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b1, a, b, 1'b0);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every edge presents one response, compared against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("dataout_A_8", bus8.dataout_A, e.a8);
                check("dataout_B_8", bus8.dataout_B, e.b8);
                check("busy_8", {7'd0, bus8.busy}, {7'd0, e.bz8});
                check("dataout_A_6", bus6.dataout_A, e.a6);
                check("dataout_B_6", bus6.dataout_B, e.b6);
                check("busy_6", {7'd0, bus6.busy}, {7'd0, e.bz6});
            end
        end
    end

    initial begin
        drive(1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
        rd(3'd0, 3'd7);
        drive(1'b0, 8'h05, 8'h00, 2'd0, 1'b1, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0);
        rd(3'd2, 3'd0);
        drive(1'b0, 8'h00, 8'h07, 2'd1, 1'b1, 3'd3, 1'b1, 3'd3, 3'd2, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 2'd2, 1'b1, 3'd5, 1'b0, 3'd2, 3'd0, 1'b0);
        rd(3'd5, 3'd2);
        drive(1'b0, 8'h09, 8'h00, 2'd0, 1'b1, 3'd7, 1'b0, 3'd0, 3'd0, 1'b0);
        rd(3'd7, 3'd5);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd3, 1'b1);
        drive(1'b0, 8'hAA, 8'h00, 2'd0, 1'b1, 3'd2, 1'b1, 3'd2, 3'd3, 1'b1);
        rd(3'd2, 3'd3);
        drive(1'b0, 8'h00, 8'h00, 2'd3, 1'b1, 3'd5, 1'b1, 3'd5, 3'd3, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd3, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd1, 3'd6, 1'b1);
        idle();
        rd(3'd1, 3'd6);
        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd3, 1'b1);
        drive(1'b1, 8'h33, 8'h00, 2'd0, 1'b1, 3'd2, 1'b1, 3'd2, 3'd3, 1'b1);
        rd(3'd2, 3'd3);
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 63) == 0), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
        end
        idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 8, register and data-path width in bits.
REQ-002 Parameter NUM_REGS, default 8, number of registers (2..256; need not be a power of two).
REQ-003 Parameter ADDR_W, default 3, address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 or_in  input  DATA_W  operand-register write source.
REQ-007 alu_in  input  DATA_W  ALU result write source.
REQ-008 mux_sel  input  2  write source: 00 or_in, 01 alu_in, 10 regs[rs_a] (move), 11 zero.
REQ-009 wr_en  input  1  write request.
REQ-010 wr_addr  input  ADDR_W  write destination.
REQ-011 rd_en  input  1  read request for both ports.
REQ-012 rs_a, rs_b  input  ADDR_W each  read / move / swap source addresses.
REQ-013 swap_req  input  1  exchange regs[rs_a] and regs[rs_b].
REQ-014 dataout_A, dataout_B  output  DATA_W each  registered read data.
REQ-015 busy  output  1  registered; high while a swap is in its second cycle.

Function
REQ-016 FSM states IDLE and SWAP2; only IDLE accepts requests.
REQ-017 IDLE priority: swap_req over wr_en/rd_en; when swap_req=1, the same-cycle wr_en and rd_en are ignored.
REQ-018 Write: in IDLE with wr_en=1 and swap_req=0, regs[wr_addr] <= selected source at the edge; move (10) uses the pre-edge value of regs[rs_a].
REQ-019 Read: in IDLE with rd_en=1 and swap_req=0, dataout_A <= regs[rs_a] and dataout_B <= regs[rs_b] at the edge; latency 1 cycle.
REQ-020 Bypass: read and write in the same cycle with rs_x == wr_addr; the affected port returns the newly written value.
REQ-021 With no read, dataout_A and dataout_B hold their values.
REQ-022 Swap cycle 1 (IDLE, swap_req=1): tmp <= regs[rs_a]; regs[rs_a] <= regs[rs_b]; rs_b latched; busy <= 1; next state SWAP2.
REQ-023 Swap cycle 2 (SWAP2): regs[latched rs_b] <= tmp; busy <= 0; next state IDLE; wr_en, rd_en and swap_req are ignored in this cycle.
REQ-024 Swap with rs_a == rs_b completes the full two-cycle sequence and leaves the register unchanged.
REQ-025 Out-of-range address (>= NUM_REGS): writes are discarded; reads and moves read 0; a swap touching such an address is dropped entirely, and busy stays 0.
REQ-026 Back-to-back swaps: a new swap_req is accepted only in the cycle after busy has returned to 0.
REQ-027 Zero source (11) clears the destination register.

Reset
REQ-028 rst=1 at an edge: all registers, tmp, dataout_A and dataout_B become 0, busy becomes 0 and the state becomes IDLE.
REQ-029 rst has priority over every request, including a swap in SWAP2; an aborted swap leaves all registers 0.
REQ-030 The first request is accepted in the cycle after rst deasserts.

Verification (DATA_W=8, NUM_REGS=8)
REQ-031 Reset, then read rs_a=0, rs_b=7 -> dataout_A=0x00, dataout_B=0x00, busy=0.
REQ-032 Write or_in=0x05 to r2 (mux_sel 00); next cycle read rs_a=2 -> dataout_A=0x05 one cycle later.
REQ-033 Same cycle: write alu_in=0x07 to r3 and read rs_a=3, rs_b=2 -> dataout_A=0x07 (bypass), dataout_B=0x05.
REQ-034 Move r2->r5 (mux_sel 10, rs_a=2, wr_addr=5), then read rs_a=5 -> 0x05; write 0x09 to r7 with wr_addr=7 accepted; NUM_REGS=6 build: write to 7 is discarded and reads return 0.
REQ-035 Swap rs_a=2 (0x05), rs_b=3 (0x07) -> busy high for exactly one cycle; wr_en to r2 during busy is ignored; then read -> r2=0x07, r3=0x05.
REQ-036 Assert rst during SWAP2 -> next cycle busy=0, state IDLE, reads of r2 and r3 return 0x00.
